// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: FSM state encoding and default widths.
package mem_access_unit_pkg;

    localparam int DEF_ADDR_W         = 16;
    localparam int DEF_DATA_W         = 16;
    localparam int DEF_TIMEOUT_CYCLES = 15;

    // Encoding 2'd3 is deliberately left unnamed; the FSM recovers from it to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_access_unit.sv
// Memory access unit: serialises instruction fetches and data loads/stores from the
// control unit onto a single request/acknowledge memory bus.
// Optional feature: define MEM_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES cycles
// without bus_ack (target register gets all-ones, bus_err pulses for one cycle).
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              mem_en,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              need_wait,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              bus_err,
    output logic [1:0]        dbg_state
);

    // The timeout counter is 8 bits wide, so only 1..255 is meaningful.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_check
        $error("mem_access_unit: TIMEOUT_CYCLES must be in 1..255");
    end

    state_t            state;
    state_t            state_next;
    logic              req_fetch;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              timeout_hit;
    logic              start_req;

    assign start_req = (state == ST_IDLE) && (fetch_en || mem_en);
    assign dbg_state = state;

    // Stall is purely combinational so the first enabled cycle stalls with no latency.
    assign need_wait = (fetch_en || mem_en) && (state != ST_DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and bus drive; the bus is only driven while BUSY.
    always_comb begin
        state_next = ST_IDLE;
        bus_req    = 1'b0;
        bus_we     = 1'b0;
        bus_addr   = '0;
        bus_wdata  = '0;
        case (state)
            ST_IDLE: begin
                if (fetch_en || mem_en) begin
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                bus_req   = 1'b1;
                bus_we    = req_we;
                bus_addr  = req_addr;
                bus_wdata = req_wdata;
                if (bus_ack || timeout_hit) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Latch the winning request on leaving IDLE; fetch has priority over data access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_fetch <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else if (start_req) begin
            if (fetch_en) begin
                req_fetch <= 1'b1;
                req_we    <= 1'b0;
                req_addr  <= pc;
                req_wdata <= '0;
            end else begin
                req_fetch <= 1'b0;
                req_we    <= mem_we;
                req_addr  <= addr;
                req_wdata <= wdata;
            end
        end
    end

    // Capture returned data (or all-ones on timeout) into the target register; writes touch neither.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= '0;
            rdata <= '0;
        end else if (state == ST_BUSY) begin
            if (bus_ack) begin
                if (req_fetch) begin
                    instr <= bus_rdata;
                end else if (!req_we) begin
                    rdata <= bus_rdata;
                end
            end else if (timeout_hit) begin
                if (req_fetch) begin
                    instr <= '1;
                end else if (!req_we) begin
                    rdata <= '1;
                end
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt;
    logic       bus_err_q;

    // An ack always wins over a timeout that would expire on the same cycle.
    assign timeout_hit = (state == ST_BUSY) && !bus_ack && (tmo_cnt == TMO_LAST);
    assign bus_err     = bus_err_q;

    // Count BUSY cycles without ack; cleared whenever a new access enters BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= 8'd0;
        end else if (start_req) begin
            tmo_cnt <= 8'd0;
        end else if ((state == ST_BUSY) && !bus_ack) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // One-cycle error pulse, high during the DONE cycle that follows an abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_W, default 16: bus and request address width.
REQ-002 Parameter DATA_W, default 16: instruction and data word width.
REQ-003 Parameter TIMEOUT_CYCLES, default 15: BUSY cycles without bus_ack before abort; applies only with MEM_TIMEOUT_EN; legal range 1..255.
REQ-004 Port clk, input, 1: sole clock; all state changes on rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Ports fetch_en and mem_en, input, 1 each: access strobes from the control unit; held high until need_wait is sampled low.
REQ-007 Port mem_we, input, 1: with mem_en, selects write (1) or read (0); ignored for fetch.
REQ-008 Ports pc and addr, input, ADDR_W each: fetch address and data address.
REQ-009 Port wdata, input, DATA_W: store data.
REQ-010 Port need_wait, output, 1: stall to the control unit.
REQ-011 Ports instr and rdata, output, DATA_W each: registered fetched instruction and registered load data.
REQ-012 Ports bus_req and bus_we, output, 1 each; bus_addr, output, ADDR_W; bus_wdata, output, DATA_W: memory-side request.
REQ-013 Ports bus_rdata, input, DATA_W, and bus_ack, input, 1: memory-side response; bus_ack is a one-cycle completion pulse.
REQ-014 Port bus_err, output, 1: one-cycle timeout pulse.
REQ-015 Port dbg_state, output, 2: current FSM state encoding.

Function
REQ-016 FSM states: IDLE=0, BUSY=1, DONE=2; encoding 3 is unreachable and recovers to IDLE on the next edge.
REQ-017 IDLE with fetch_en or mem_en high: latch request and go to BUSY on the next edge; with both high, fetch wins and mem_en is served in a later access.
REQ-018 need_wait is combinational: (fetch_en | mem_en) and state != DONE, so the first enabled cycle is stalled with zero latency.
REQ-019 BUSY drives bus_req=1 and the latched bus_addr, bus_we and bus_wdata; all are stable until exit.
REQ-020 BUSY with bus_ack=1: capture bus_rdata into instr (fetch) or rdata (read) on that edge and go to DONE; writes leave both unchanged.
REQ-021 DONE: bus_req=0, need_wait=0; always return to IDLE on the next edge, even if an enable is still high.
REQ-022 Minimum access: 3 cycles (IDLE, BUSY with ack, DONE); each further BUSY cycle adds one.
REQ-023 bus_ack outside BUSY is ignored.
REQ-024 An enable dropping during BUSY does not abort the access; it completes and the result is still captured.
REQ-025 instr and rdata hold their value between accesses.
REQ-026 bus_req, bus_we, bus_addr and bus_wdata are 0 outside BUSY.

Reset
REQ-027 rst_n low forces IDLE, instr=0, rdata=0, bus_req=0, bus_err=0 and the timeout counter to 0, immediately and regardless of clk.
REQ-028 Reset during BUSY abandons the access; the first access after reset starts clean.

Configuration
REQ-029 With MEM_TIMEOUT_EN defined: an 8-bit counter increments each BUSY cycle without ack. On reaching TIMEOUT_CYCLES: go to DONE, load all-ones into the target register (none for a write), pulse bus_err for one cycle. The counter clears on BUSY entry.
REQ-030 Without MEM_TIMEOUT_EN: no counter; BUSY waits indefinitely; bus_err is tied 0.

Structure
REQ-031 A shared package holds the state encoding constants (ST_IDLE, ST_BUSY, ST_DONE) and the default widths.
REQ-032 No sub-module; a single flat FSM plus datapath registers.

Verification
REQ-033 fetch_en=1, pc=0x0010, bus_ack on the first BUSY cycle with bus_rdata=0xA5A5 -> need_wait high 2 cycles then low; instr=0xA5A5 in DONE.
REQ-034 mem_en=1, mem_we=1, addr=0x0200, wdata=0x1234, ack after 3 BUSY cycles -> bus_we=1, bus_wdata=0x1234 held 3 cycles; rdata unchanged.
REQ-035 fetch_en and mem_en both high -> fetch served first, then mem read served after return to IDLE.
REQ-036 rst_n pulsed low mid-BUSY -> bus_req=0 immediately; IDLE after release; a new fetch completes normally.
REQ-037 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> DONE after 4 BUSY cycles, bus_err=1 for one cycle, instr=0xFFFF.
REQ-038 Spurious bus_ack in IDLE -> no state change; instr and rdata unchanged.
